// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 then an opcode-specific execute
// sequence, driving datapath strobes decoded from the state and IR opcode.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             Rout,
  output logic             BAout,
  output logic             Cout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Rin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic [4:0]       operation,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_retired;

  logic [4:0] w_op;
  logic       w_rtype;
  logic       w_imm;
  logic       w_ldi;
  logic       w_ld;
  logic       w_st;
  logic       w_halt;
  logic       w_mem;
  logic       w_long;
  logic       w_short;
  logic       w_end;
  logic [4:0] w_alu_op;
  logic       w_unused;

  assign w_op     = ir[31:27];
  assign w_unused = ^ir[26:0];
  assign w_rtype  = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
  assign w_ldi    = (w_op == 5'd1);
  assign w_ld     = (w_op == 5'd0);
  assign w_st     = (w_op == 5'd2);
  assign w_halt   = (w_op == 5'd27);
  assign w_mem    = w_ldi | w_ld | w_st;
  assign w_long   = w_ld | w_st;
  assign w_short  = !(w_rtype | w_imm | w_mem);

  // Final T-state of the current instruction (halt is handled separately).
  assign w_end = ((r_state == S_T2) && w_short && !w_halt)
               || ((r_state == S_T5) && !w_long)
               || (r_state == S_T7);

  always_comb begin
    w_alu_op = 5'd3;
    unique case (1'b1)
      w_rtype:          w_alu_op = w_op;
      w_op == 5'd13:    w_alu_op = 5'd5;
      w_op == 5'd14:    w_alu_op = 5'd6;
      default:          w_alu_op = 5'd3;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else if (w_end) begin
      r_retired <= r_retired + CNT_W'(1);
      r_state   <= run ? S_T0 : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= S_T2;
        S_T2: begin
          if (w_halt) begin
            r_state   <= S_HALT;
            r_retired <= r_retired + CNT_W'(1);
          end else begin
            r_state <= S_T3;
          end
        end
        S_T3:   r_state <= S_T4;
        S_T4:   r_state <= S_T5;
        S_T5:   r_state <= S_T6;
        S_T6:   r_state <= S_T7;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    Rout  = 1'b0; BAout   = 1'b0; Cout   = 1'b0;
    MARin = 1'b0; PCin    = 1'b0; MDRin  = 1'b0;
    IRin  = 1'b0; Yin     = 1'b0; Zin    = 1'b0;
    Rin   = 1'b0; Gra     = 1'b0; Grb    = 1'b0;
    Grc   = 1'b0; IncPC   = 1'b0; Read   = 1'b0;
    Write = 1'b0; operation = 5'd0;
    unique case (r_state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Grb = 1'b1; Yin = 1'b1;
        BAout = w_mem;
        Rout  = !w_mem;
      end
      S_T4: begin
        Zin       = 1'b1;
        operation = w_alu_op;
        Grc       = w_rtype;
        Rout      = w_rtype;
        Cout      = !w_rtype;
      end
      S_T5: begin
        Zlowout = 1'b1;
        MARin   = w_long;
        Gra     = !w_long;
        Rin     = !w_long;
      end
      S_T6: begin
        MDRin = 1'b1;
        Gra   = w_st;
        Rout  = w_st;
        Read  = !w_st;
      end
      S_T7: begin
        Write  = w_st;
        MDRout = !w_st;
        Gra    = !w_st;
        Rin    = !w_st;
      end
      default: ;
    endcase
  end

  assign running = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

endmodule
